// File: rtl/dmx_tx_pkg.sv
// Shared definitions for the DMX512 transmitter: FSM states, frame geometry and
// the slot shift-register layout.
package dmx_tx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBreak,
    StMab,
    StSlot
  } dmx_state_e;

  localparam int unsigned BREAK_BITS    = 23;
  localparam int unsigned MAB_BITS      = 3;
  localparam int unsigned SLOT_BITS     = 11;
  localparam int unsigned NUM_CHANNELS  = 512;
  localparam logic [7:0]  START_CODE    = 8'h00;
  localparam int unsigned CTRL_ADDR_BIT = 9;

  // Shift-register image of a slot after the start bit: data LSB first, then two stop bits.
  function automatic logic [9:0] slot_frame(input logic [7:0] data);
    return {2'b11, data};
  endfunction

endpackage

// File: rtl/dmx_dpram.sv
// 512x8 true dual-port RAM with synchronous reads; port 1 read/write, port 2 read-only.
// A read that coincides with a write to the same address returns the old contents.
module dmx_dpram
  import dmx_tx_pkg::*;
(
  input  logic       clk,
  input  logic [8:0] p1_addr,
  input  logic       p1_we,
  input  logic [7:0] p1_wdata,
  output logic [7:0] p1_rdata,
  input  logic [8:0] p2_addr,
  output logic [7:0] p2_rdata
);

  logic [7:0] mem [NUM_CHANNELS];

  always_ff @(posedge clk) begin
    if (p1_we) begin
      mem[p1_addr] <= p1_wdata;
    end
    p1_rdata <= mem[p1_addr];
    p2_rdata <= mem[p2_addr];
  end

endmodule

// File: rtl/dmx_tx.sv
// DMX512 transmitter: CSR-written channel RAM, continuously framed out on tx at 250 kbaud
// (break, mark-after-break, start code, 512 slots in 8N2) while enabled.
module dmx_tx
  import dmx_tx_pkg::*;
#(
  parameter logic [3:0]  csr_addr = 4'h0,
  parameter int unsigned clk_freq = 100000000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  output logic        tx
);

  localparam logic [15:0] BitTime = 16'(clk_freq / 250000);
  localparam logic [15:0] BtLast  = BitTime - 16'd1;

  dmx_state_e  state_q;
  logic        enable_q, tx_q;
  logic [15:0] bt_cnt_q;
  logic [4:0]  bit_cnt_q;
  logic [9:0]  slot_q, shift_q;
  logic        sel_q, ctrl_sel_q;
  logic [1:0]  ctrl_rd_q;
  logic [7:0]  ram_csr_rdata, ram_tx_rdata;
  logic        sel, ram_we, ctrl_we, busy, tick;
  logic        unused_csr_di;

  assign sel           = csr_a[13:10] == csr_addr;
  assign ram_we        = sel & csr_we & ~csr_a[CTRL_ADDR_BIT];
  assign ctrl_we       = sel & csr_we & csr_a[CTRL_ADDR_BIT];
  assign busy          = state_q != StIdle;
  assign tick          = bt_cnt_q == '0;
  assign tx            = tx_q;
  assign unused_csr_di = ^csr_di[31:8];

  // Port 2 address is the RAM index of the *next* slot: (slot_q + 1) - 1.
  dmx_dpram u_ram (
    .clk      (sys_clk),
    .p1_addr  (csr_a[8:0]),
    .p1_we    (ram_we),
    .p1_wdata (csr_di[7:0]),
    .p1_rdata (ram_csr_rdata),
    .p2_addr  (slot_q[8:0]),
    .p2_rdata (ram_tx_rdata)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      enable_q   <= 1'b0;
      sel_q      <= 1'b0;
      ctrl_sel_q <= 1'b0;
      ctrl_rd_q  <= '0;
    end else begin
      if (ctrl_we) begin
        enable_q <= csr_di[0];
      end
      sel_q      <= sel;
      ctrl_sel_q <= csr_a[CTRL_ADDR_BIT];
      ctrl_rd_q  <= {busy, enable_q};
    end
  end

  // All read sources are flops, so the mux still gives a one-cycle registered read.
  always_comb begin
    csr_do = '0;
    if (sel_q) begin
      csr_do = ctrl_sel_q ? {30'h0, ctrl_rd_q} : {24'h0, ram_csr_rdata};
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= StIdle;
      tx_q      <= 1'b1;
      bt_cnt_q  <= '0;
      bit_cnt_q <= '0;
      slot_q    <= '0;
      shift_q   <= '0;
    end else if (state_q == StIdle) begin
      if (enable_q) begin
        state_q   <= StBreak;
        tx_q      <= 1'b0;
        bt_cnt_q  <= BtLast;
        bit_cnt_q <= '0;
      end
    end else if (!tick) begin
      bt_cnt_q <= bt_cnt_q - 16'd1;
    end else begin
      bt_cnt_q  <= BtLast;
      bit_cnt_q <= bit_cnt_q + 5'd1;
      case (state_q)
        StBreak: begin
          if (bit_cnt_q == 5'(BREAK_BITS - 1)) begin
            state_q   <= StMab;
            tx_q      <= 1'b1;
            bit_cnt_q <= '0;
          end
        end
        StMab: begin
          if (bit_cnt_q == 5'(MAB_BITS - 1)) begin
            state_q   <= StSlot;
            tx_q      <= 1'b0;
            bit_cnt_q <= '0;
            slot_q    <= '0;
            shift_q   <= slot_frame(START_CODE);
          end
        end
        StSlot: begin
          if (bit_cnt_q != 5'(SLOT_BITS - 1)) begin
            tx_q    <= shift_q[0];
            shift_q <= {1'b1, shift_q[9:1]};
          end else if (slot_q != 10'(NUM_CHANNELS)) begin
            slot_q    <= slot_q + 10'd1;
            tx_q      <= 1'b0;
            bit_cnt_q <= '0;
            shift_q   <= slot_frame(ram_tx_rdata);
          end else if (enable_q) begin
            state_q   <= StBreak;
            tx_q      <= 1'b0;
            bit_cnt_q <= '0;
          end else begin
            state_q   <= StIdle;
            tx_q      <= 1'b1;
            bit_cnt_q <= '0;
            bt_cnt_q  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmx_tx.sv
// Scoreboard bench for dmx_tx: expected tx segments and CSR read data are queued by the
// stimulus and checked by independent monitors.
module tb_dmx_tx;

  localparam int unsigned ClkFreq  = 1000000;
  localparam int          Bt       = ClkFreq / 250000;
  localparam int          FrameCyc = (23 + 3 + 513 * 11) * Bt;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [13:0] csr_a = '0;
  logic        csr_we = 1'b0;
  logic [31:0] csr_di = '0;
  logic [31:0] csr_do;
  logic        tx;

  dmx_tx #(
    .csr_addr (4'h0),
    .clk_freq (ClkFreq)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .csr_a     (csr_a),
    .csr_we    (csr_we),
    .csr_di    (csr_di),
    .csr_do    (csr_do),
    .tx        (tx)
  );

  always #5 sys_clk = ~sys_clk;

  // kind: 0 lead-in, 1 break, 2 mab, 3 slot, 4 idle; bits sent LSB first, cyc clocks each
  typedef struct {
    int          kind;
    int          idx;
    int          nbits;
    int          cyc;
    logic [22:0] bits;
  } seg_t;

  seg_t        txq[$];
  logic [45:0] csrq[$];
  logic [7:0]  model [512];
  logic        rd_req = 1'b0;
  bit          mon_active = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          w_cyc;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic push_seg(input int kind, input int idx, input int nbits, input int c,
                          input logic [22:0] bits);
    seg_t s;
    s.kind = kind;
    s.idx = idx;
    s.nbits = nbits;
    s.cyc = c;
    s.bits = bits;
    txq.push_back(s);
  endtask

  task automatic push_frame();
    logic [7:0] d;
    push_seg(1, 0, 23, Bt, 23'h0);
    push_seg(2, 0, 3, Bt, 23'h7);
    for (int s = 0; s <= 512; s++) begin
      d = 8'h00;
      if (s > 0) d = model[s-1];
      push_seg(3, s, 11, Bt, {12'h0, 2'b11, d, 1'b0});
    end
  endtask

  task automatic csr_write(input logic [13:0] a, input logic [31:0] d, input bit start);
    @(negedge sys_clk);
    csr_a = a;
    csr_di = d;
    csr_we = 1'b1;
    if (a[13:10] == 4'h0 && !a[9]) model[a[8:0]] = d[7:0];
    if (start) begin
      push_seg(0, 0, 1, 1, 23'h1);
      push_frame();
    end
    @(negedge sys_clk);
    csr_we = 1'b0;
  endtask

  task automatic csr_read(input logic [13:0] a, input logic [31:0] want);
    @(negedge sys_clk);
    csr_a = a;
    csr_we = 1'b0;
    rd_req = 1'b1;
    csrq.push_back({a, want});
    @(negedge sys_clk);
    rd_req = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge sys_clk);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((txq.size() != 0 || mon_active) && n < 2 * FrameCyc) begin
      @(negedge sys_clk);
      n++;
    end
    n_cmp++;
    if (n >= 2 * FrameCyc) begin
      n_err++;
      $display("FAIL %s timeout got=%0d segments left want=0", name, txq.size());
    end
  endtask

  // CSR monitor: response appears one cycle after the address edge.
  initial forever begin
    logic [45:0] e;
    @(posedge sys_clk);
    if (rd_req) begin
      @(negedge sys_clk);
      n_cmp++;
      if (csrq.size() == 0) begin
        n_err++;
        $display("FAIL csr_read unexpected got=%h want=none", csr_do);
      end else begin
        e = csrq.pop_front();
        if (csr_do !== e[31:0]) begin
          n_err++;
          $display("FAIL csr_read addr=%h got=%h want=%h", e[45:32], csr_do, e[31:0]);
        end
      end
    end
  end

  // TX monitor: consumes segments back to back, so any timing slip shows up as a bad pattern.
  initial forever begin
    seg_t        s;
    logic [22:0] act;
    bit          stable;
    while (txq.size() == 0) @(posedge sys_clk);
    s = txq.pop_front();
    mon_active = 1'b1;
    act = '0;
    stable = 1'b1;
    for (int i = 0; i < s.nbits; i++) begin
      for (int j = 0; j < s.cyc; j++) begin
        @(negedge sys_clk);
        if (j == 0) act[i] = tx;
        else if (tx !== act[i]) stable = 1'b0;
      end
    end
    n_cmp++;
    if (!stable || act !== s.bits) begin
      n_err++;
      $display("FAIL tx_seg kind=%0d idx=%0d got=%b want=%b stable=%0d",
               s.kind, s.idx, act, s.bits, stable);
    end
    mon_active = 1'b0;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge sys_clk);
    chk("tx_in_reset", {31'h0, tx}, 32'h1);
    sys_rst_n = 1'b1;
    chk("tx_after_reset", {31'h0, tx}, 32'h1);
    csr_read(14'h200, 32'h0);
    csr_read(14'h600, 32'h0);

    for (int i = 0; i < 512; i++) csr_write(14'(i), 32'((i * 7 + 3) & 255), 1'b0);
    csr_write(14'h000, 32'hFFFF_FFA5, 1'b0);
    csr_write(14'h1FF, 32'h0000_003C, 1'b0);
    csr_read(14'h000, 32'h0000_00A5);
    csr_read(14'h1FF, 32'h0000_003C);
    csr_read(14'h400, 32'h0);
    csr_read(14'h005, 32'h0000_0026);

    // Frame 1: lead-in cycle, then break/MAB/slots queued against the current RAM image.
    csr_write(14'h200, 32'h1, 1'b1);
    w_cyc = cyc;
    // Write ch9 on the very edge that fetches it for slot 10: old value this frame.
    wait_until(w_cyc + 26 * Bt + 110 * Bt - 2);
    csr_write(14'h009, 32'h0000_00C3, 1'b0);
    csr_write(14'h005, 32'h0000_0011, 1'b0);
    csr_read(14'h200, 32'h3);
    push_frame();

    // Frame 2 follows with no gap; drop enable mid-frame, line must then idle high.
    wait_until(w_cyc + 1 + FrameCyc + 26 * Bt + 100 * 11 * Bt + 5);
    csr_write(14'h200, 32'h0, 1'b0);
    csr_read(14'h200, 32'h2);
    push_seg(4, 0, 23, Bt, 23'h7F_FFFF);
    drain("frames");
    csr_read(14'h200, 32'h0);

    // Asynchronous reset in the middle of a low data bit (slot 1, d1 of 0xA5).
    csr_write(14'h200, 32'h1, 1'b0);
    w_cyc = cyc;
    wait_until(w_cyc + 1 + 26 * Bt + 11 * Bt + 2 * Bt + 1);
    chk("tx_before_rst", {31'h0, tx}, 32'h0);
    #1 sys_rst_n = 1'b0;
    #1 chk("tx_async_rst", {31'h0, tx}, 32'h1);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    push_seg(4, 1, 23, 2 * Bt, 23'h7F_FFFF);
    csr_read(14'h200, 32'h0);
    drain("post_reset");
    csr_read(14'h200, 32'h0);
    repeat (2) @(negedge sys_clk);
    chk("csr_queue_empty", csrq.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
